// File: rtl/ctrl_bubble_stage.sv
// Control-word bubble stage between the control unit and ID/EX.
// Inserts N NOP control words ahead of the instruction in ID, or kills it on flush.
module ctrl_bubble_stage #(
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] NOP_WORD = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              bubble_req,
    input  logic [CNT_W-1:0]  bubble_cnt,
    input  logic              flush,
    input  logic              hold,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              busy,
    output logic [15:0]       nop_count,
    output logic              dbg_state
);

    // Handshake: busy is the stall request back to PC and IF/ID. While busy=1
    // the instruction in ID must stay put; ctrl_in is consumed only on a
    // rising edge with busy=0, hold=0 and flush=0. hold freezes this stage.

    typedef enum logic {
        ST_PASS   = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CTRL_W-1:0] ctrl_out_q, ctrl_out_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [15:0]       nop_count_q, nop_count_d;
    logic              req_ok;
    logic              load_nop;

    // A zero count is treated as no request at all.
    assign req_ok = bubble_req && (bubble_cnt != '0);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        ctrl_out_d   = ctrl_out_q;
        ctrl_valid_d = ctrl_valid_q;
        load_nop     = 1'b0;
        busy         = 1'b0;

        if (!flush) begin
            busy = (state_q == ST_BUBBLE) || req_ok;
        end

        if (flush) begin
            state_d  = ST_PASS;
            rem_d    = '0;
            load_nop = 1'b1;
        end else if (hold) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_PASS: begin
                    if (req_ok) begin
                        rem_d    = bubble_cnt - CNT_W'(1);
                        state_d  = (bubble_cnt > CNT_W'(1)) ? ST_BUBBLE : ST_PASS;
                        load_nop = 1'b1;
                    end else begin
                        ctrl_out_d   = ctrl_in;
                        ctrl_valid_d = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    rem_d    = rem_q - CNT_W'(1);
                    state_d  = (rem_q <= CNT_W'(1)) ? ST_PASS : ST_BUBBLE;
                    load_nop = 1'b1;
                end
                default: begin
                    state_d = ST_PASS;
                    rem_d   = '0;
                end
            endcase
        end

        if (load_nop) begin
            ctrl_out_d   = NOP_WORD;
            ctrl_valid_d = 1'b0;
        end

        nop_count_d = nop_count_q;
        if (load_nop && (nop_count_q != 16'hFFFF)) begin
            nop_count_d = nop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PASS;
            rem_q        <= '0;
            ctrl_out_q   <= NOP_WORD;
            ctrl_valid_q <= 1'b0;
            nop_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            ctrl_out_q   <= ctrl_out_d;
            ctrl_valid_q <= ctrl_valid_d;
            nop_count_q  <= nop_count_d;
        end
    end

    assign ctrl_out   = ctrl_out_q;
    assign ctrl_valid = ctrl_valid_q;
    assign nop_count  = nop_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Randomized bench for ctrl_bubble_stage against a pending-bubble count model.
module tb_ctrl_bubble_stage;

    logic        clk;
    logic        rst;
    logic [23:0] ctrl_in;
    logic        bubble_req;
    logic [2:0]  bubble_cnt;
    logic        flush;
    logic        hold;
    logic [23:0] ctrl_out;
    logic        ctrl_valid;
    logic        busy;
    logic [15:0] nop_count;
    logic        dbg_state;

    int n_checks;
    int n_errors;

    // Model: number of NOP loads still owed, plus the visible registers.
    logic [23:0] m_out;
    logic        m_valid;
    int          m_pend;
    int          m_cnt;
    bit          m_init;

    ctrl_bubble_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_in    (ctrl_in),
        .bubble_req (bubble_req),
        .bubble_cnt (bubble_cnt),
        .flush      (flush),
        .hold       (hold),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .nop_count  (nop_count),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic q, input logic [2:0] c,
                              input logic f, input logic h, input logic [23:0] d);
        bit nop;
        nop = 1'b0;
        if (r) begin
            m_out = '0; m_valid = 1'b0; m_pend = 0; m_cnt = 0; m_init = 1'b1;
            return;
        end
        if (f) begin
            nop = 1'b1; m_pend = 0;
        end else if (h) begin
            return;
        end else if (m_pend > 0) begin
            nop = 1'b1; m_pend = m_pend - 1;
        end else if (q && c != 0) begin
            nop = 1'b1; m_pend = int'(c) - 1;
        end else begin
            m_out = d; m_valid = 1'b1;
        end
        if (nop) begin
            m_out = '0; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [2:0] c,
                        input logic f, input logic h, input logic [23:0] d);
        @(negedge clk);
        rst = r; bubble_req = q; bubble_cnt = c; flush = f; hold = h; ctrl_in = d;
        #1;
        if (m_init) check("busy", busy, !f && (m_pend > 0 || (q && c != 0)));
        @(posedge clk);
        model_edge(r, q, c, f, h, d);
        #1;
        check("ctrl_out", ctrl_out, m_out);
        check("ctrl_valid", ctrl_valid, m_valid);
        check("nop_count", nop_count, m_cnt);
        check("state", dbg_state, m_pend > 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_out = '0; m_valid = 1'b0; m_pend = 0; m_cnt = 0; m_init = 1'b0;
        rst = 1'b1; ctrl_in = '0; bubble_req = 1'b0; bubble_cnt = '0; flush = 1'b0; hold = 1'b0;

        // Reset, then pass-through.
        step(1, 0, 0, 0, 0, 24'h0);
        step(1, 1, 3, 1, 1, 24'h111111);
        step(0, 0, 0, 0, 0, 24'hA5A5A5);
        check("pass_out", ctrl_out, 24'hA5A5A5);
        check("pass_cnt", nop_count, 16'd0);

        // Load-use single bubble.
        step(0, 1, 1, 0, 0, 24'h000123);
        step(0, 0, 0, 0, 0, 24'h000123);
        check("loaduse_out", ctrl_out, 24'h000123);
        check("loaduse_cnt", nop_count, 16'd1);

        // Four bubbles with hold on the second bubble cycle.
        step(1, 0, 0, 0, 0, 24'h0);
        step(0, 1, 4, 0, 0, 24'h0000AA);
        step(0, 0, 0, 0, 1, 24'h0000AA);
        step(0, 0, 0, 0, 0, 24'h0000AA);
        step(0, 0, 0, 0, 0, 24'h0000AA);
        step(0, 0, 0, 0, 0, 24'h0000AA);
        check("multi_cnt", nop_count, 16'd4);
        step(0, 0, 0, 0, 0, 24'h0000AA);
        check("multi_out", ctrl_out, 24'h0000AA);

        // Flush on the third cycle of a five-bubble request.
        step(1, 0, 0, 0, 0, 24'h0);
        step(0, 1, 5, 0, 0, 24'h0000BB);
        step(0, 1, 5, 0, 0, 24'h0000BB);
        step(0, 0, 0, 1, 0, 24'h0000BB);
        check("flush_cnt", nop_count, 16'd3);
        step(0, 0, 0, 0, 0, 24'h0000BB);
        check("flush_out", ctrl_out, 24'h0000BB);

        // Zero count, flush with hold, re-request inside BUBBLE.
        step(0, 1, 0, 0, 0, 24'h0000CC);
        step(0, 0, 0, 1, 1, 24'h0000DD);
        check("flush_hold_valid", ctrl_valid, 1'b0);
        step(0, 1, 2, 0, 0, 24'h0000EE);
        step(0, 1, 7, 0, 0, 24'h0000EE);
        step(0, 0, 0, 0, 0, 24'h0000EE);
        check("rearm_out", ctrl_out, 24'h0000EE);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, 24'($urandom));
        end

        // Saturation.
        step(1, 0, 0, 0, 0, 24'h0);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 1, 0, 24'h0);
        check("saturate", nop_count, 16'hFFFF);

        // Reset in the middle of a bubble run.
        step(0, 1, 6, 0, 0, 24'h000077);
        step(0, 0, 0, 0, 0, 24'h000077);
        step(1, 0, 0, 0, 0, 24'h000077);
        check("rst_cnt", nop_count, 16'd0);
        check("rst_out", ctrl_out, 24'h0);
        step(0, 0, 0, 0, 0, 24'h000077);
        check("rst_release_out", ctrl_out, 24'h000077);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
